// File: rtl/ram_march_bist_if.sv
// RAM-side bus of the March C- BIST: host request signals in, RAM port out.
// master = BIST/mux side, slave = host + RAM side.
interface ram_march_bist_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) ();
  // No valid/ready pair on this bus: every cycle is a RAM operation. A write
  // happens in any cycle with ram_we=1. ram_dout carries the word addressed in
  // the previous cycle. The host side is only honoured while the BIST is idle.
  logic                  host_we;
  logic [AW-1:0]         host_addr;
  logic [DATA_WIDTH-1:0] host_din;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    input  host_we, host_addr, host_din, ram_dout,
    output ram_we, ram_addr, ram_din
  );

  modport slave (
    output host_we, host_addr, host_din, ram_dout,
    input  ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_march_bist.sv
// March C- self-test sequencer with host pass-through mux for a synchronous-read RAM.
// Reads are checked one cycle later against the pipelined expected background.
module ram_march_bist #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  ram_march_bist_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [AW-1:0]   fail_addr,
  output logic [2:0]      fail_elem,
  output logic [7:0]      err_count,
  output logic [1:0]      dbg_state
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0]         LAST = AW'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [2:0]            elem_q, elem_d;
  logic                  phase_q, phase_d;
  logic                  cmp_valid_q, cmp_valid_d;
  logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
  logic [AW-1:0]         cmp_addr_q, cmp_addr_d;
  logic [2:0]            cmp_elem_q, cmp_elem_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [AW-1:0]         fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic                  pass_q, pass_d;

  logic                  is_down, is_read, is_write, last_addr, step, mismatch;
  logic [DATA_WIDTH-1:0] rd_bg, wr_bg;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    cmp_valid_d = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    pass_d      = pass_q;

    // M3/M4 walk downwards; M2/M4 read ones; M1/M3 write ones.
    is_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
    rd_bg     = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ONES : '0;
    wr_bg     = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ONES : '0;
    is_read   = (state_q == RUN) && (elem_q != 3'd0) && ((elem_q == 3'd5) || !phase_q);
    is_write  = (state_q == RUN) && !is_read;
    last_addr = is_down ? (addr_q == '0) : (addr_q == LAST);
    step      = (elem_q == 3'd0) || (elem_q == 3'd5) || phase_q;
    mismatch  = cmp_valid_q && (bus.ram_dout != cmp_exp_q);

    if (state_q == IDLE) begin
      bus.ram_we   = bus.host_we;
      bus.ram_addr = bus.host_addr;
      bus.ram_din  = bus.host_din;
    end else begin
      bus.ram_we   = is_write;
      bus.ram_addr = addr_q;
      bus.ram_din  = is_write ? wr_bg : '0;
    end

    if (mismatch) begin
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      if (err_count_q == 8'd0) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          addr_d      = '0;
          elem_d      = 3'd0;
          phase_d     = 1'b0;
          pass_d      = 1'b0;
          err_count_d = 8'd0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
        end
      end
      RUN: begin
        if (is_read) begin
          cmp_valid_d = 1'b1;
          cmp_exp_d   = rd_bg;
          cmp_addr_d  = addr_q;
          cmp_elem_d  = elem_q;
        end
        if (!step) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (last_addr) begin
            if (elem_q == 3'd5) begin
              state_d = DRAIN;
              addr_d  = '0;
              elem_d  = 3'd0;
            end else begin
              elem_d = elem_q + 3'd1;
              // M3 and M4 start at the top address.
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST : '0;
            end
          end else begin
            addr_d = is_down ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        pass_d  = (err_count_d == 8'd0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      elem_q      <= 3'd0;
      phase_q     <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
      err_count_q <= 8'd0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      pass_q      <= pass_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign err_count = err_count_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: RAM model with optional bit0 stuck-at-1 at address 5,
// a March C- operation model, a per-cycle compare process and directed scenarios.
module tb_ram_march_bist;
  localparam int DW = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [7:0]    err_count;
  logic [1:0]    dbg_state;

  ram_march_bist_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ram_march_bist #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM, registered output, optional stuck-at-1 on bit0 of word 5.
  logic [DW-1:0] ram_mem [DEPTH];
  logic          fault_en;
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram_mem[bus.ram_addr] | ((fault_en && bus.ram_addr == 4'd5) ? 4'h1 : 4'h0);
  end

  int checks;
  int errors;
  int run_cyc;
  bit run_active;
  bit run_done;

  // Expected RAM port operations for one run: {we, addr, din}.
  logic [8:0] exp_q[$];
  int         m_err;
  int         m_fa;
  int         m_fe;
  bit         m_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // March C-: M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 down(r0,w1) M4 down(r1,w0) M5 up(r0)
  task automatic build_model(input bit fault);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rbg, wbg, v;
    int a;
    exp_q.delete();
    m_err = 0; m_fa = 0; m_fe = 0;
    for (int e = 0; e < 6; e++) begin
      rbg = (e == 2 || e == 4) ? 4'hF : 4'h0;
      wbg = (e == 1 || e == 3) ? 4'hF : 4'h0;
      for (int i = 0; i < DEPTH; i++) begin
        a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
        if (e > 0) begin
          exp_q.push_back({1'b0, 4'(a), 4'h0});
          v = mem[a] | ((fault && a == 5) ? 4'h1 : 4'h0);
          if (v != rbg) begin
            if (m_err == 0) begin m_fa = a; m_fe = e; end
            m_err++;
          end
        end
        if (e < 5) begin
          exp_q.push_back({1'b1, 4'(a), wbg});
          mem[a] = wbg;
        end
      end
    end
    m_pass = (m_err == 0);
  endtask

  task automatic compare_loop();
    logic [8:0] op;
    forever begin
      @(negedge clk);
      if (run_active) begin
        run_cyc++;
        if (run_cyc <= 160) begin
          op = exp_q.pop_front();
          check("busy_run", 32'(busy), 32'd1);
          check("done_run", 32'(done), 32'd0);
          check("ram_we", 32'(bus.ram_we), 32'(op[8]));
          check("ram_addr", 32'(bus.ram_addr), 32'(op[7:4]));
          if (op[8]) check("ram_din", 32'(bus.ram_din), 32'(op[3:0]));
        end else if (run_cyc == 161) begin
          check("busy_drain", 32'(busy), 32'd1);
          check("done_drain", 32'(done), 32'd0);
        end else if (run_cyc == 162) begin
          check("busy_done", 32'(busy), 32'd0);
          check("done_pulse", 32'(done), 32'd1);
          check("pass", 32'(pass), 32'(m_pass));
          check("err_count", 32'(err_count), 32'(m_err));
          check("fail_addr", 32'(fail_addr), 32'(m_fa));
          check("fail_elem", 32'(fail_elem), 32'(m_fe));
        end else begin
          check("done_single", 32'(done), 32'd0);
          check("busy_after", 32'(busy), 32'd0);
          check("pass_held", 32'(pass), 32'(m_pass));
          run_active = 1'b0;
          run_done = 1'b1;
        end
      end
    end
  endtask

  task automatic launch(input bit fault);
    fault_en = fault;
    bus.host_we = 1'b1; bus.host_addr = 4'd7; bus.host_din = 4'h9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    run_cyc = 0;
    run_done = 1'b0;
    run_active = 1'b1;
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 300 && run_cyc != c; i++) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !run_done; i++) @(posedge clk);
    check("run_timeout", 32'(run_done), 32'd1);
    #1 bus.host_we = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    bus.host_we = 1'b0; bus.host_addr = a;
    @(posedge clk);
    #1 check(name, 32'(bus.ram_dout), 32'(exp));
  endtask

  initial begin
    checks = 0; errors = 0; run_cyc = 0; run_active = 1'b0; run_done = 1'b0;
    rst = 1'b1; start = 1'b0; fault_en = 1'b0;
    bus.host_we = 1'b0; bus.host_addr = 4'd9; bus.host_din = 4'h6;
    fork compare_loop(); join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_elem", 32'(fail_elem), 32'd0);
    check("rst_thru_addr", 32'(bus.ram_addr), 32'd9);
    check("rst_thru_din", 32'(bus.ram_din), 32'h6);
    rst = 1'b0;

    // Idle host write then read.
    bus.host_we = 1'b1; bus.host_addr = 4'd3; bus.host_din = 4'hA;
    #1 check("idle_thru_we", 32'(bus.ram_we), 32'd1);
    @(posedge clk);
    #1 host_read(4'd3, 4'hA, "host_rd_a");

    // Fault-free run; pin the model first.
    build_model(1'b0);
    check("mdl_len", 32'(exp_q.size()), 32'd160);
    check("mdl_m3_first_rd", 32'(exp_q[80]), 32'h0F0);
    check("mdl_m3_first_wr", 32'(exp_q[81]), 32'h1FF);
    check("mdl_m3_last_wr", 32'(exp_q[111]), 32'h10F);
    check("mdl_clean_err", 32'(m_err), 32'd0);
    launch(1'b0);
    wait_done();
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_count), 32'd0);
    host_read(4'd3, 4'h0, "host_rd_after_bist");

    // Stuck-at-1 on bit0 of word 5.
    build_model(1'b1);
    check("mdl_fault_err", 32'(m_err), 32'd3);
    check("mdl_fault_addr", 32'(m_fa), 32'd5);
    check("mdl_fault_elem", 32'(m_fe), 32'd1);
    launch(1'b1);
    wait_done();
    check("fault_pass", 32'(pass), 32'd0);
    check("fault_err", 32'(err_count), 32'd3);
    check("fault_addr", 32'(fail_addr), 32'd5);
    check("fault_elem", 32'(fail_elem), 32'd1);

    // start re-pulsed during the run must be ignored.
    build_model(1'b0);
    launch(1'b0);
    wait_cyc(39);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    check("restart_pass", 32'(pass), 32'd1);

    // Reset in the middle of a faulty run.
    build_model(1'b1);
    launch(1'b1);
    wait_cyc(49);
    check("pre_rst_err", 32'(err_count), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 run_active = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err_count), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_fail_addr", 32'(fail_addr), 32'd0);
    check("abort_thru_we", 32'(bus.ram_we), 32'd1);
    check("abort_thru_addr", 32'(bus.ram_addr), 32'd7);
    check("abort_thru_din", 32'(bus.ram_din), 32'h9);
    rst = 1'b0;
    fault_en = 1'b0;
    bus.host_we = 1'b0;
    @(posedge clk);
    #1;
    build_model(1'b0);
    launch(1'b0);
    wait_done();
    check("post_rst_pass", 32'(pass), 32'd1);
    check("post_rst_err", 32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_march_bist.md
# ram_march_bist

March C- built-in self-test sequencer and host access mux that sits directly upstream of the synchronous-read 16x4 RAM, driving its write_enable/addr/data_in and consuming its registered data_out. While idle, host-side signals pass straight through to the RAM. On start, the block takes over the RAM port, runs the full March C- sequence, compares every read against its expected background and reports pass/fail with diagnostics.

## Interface
- DATA_WIDTH, 4: RAM word width; backgrounds are all-0 and all-1 of this width.
- DEPTH, 16: RAM word count; AW = $clog2(DEPTH).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- host_we  in  1  host write enable, forwarded while idle.
- host_addr  in  AW  host address, forwarded while idle.
- host_din  in  DATA_WIDTH  host write data, forwarded while idle.
- ram_we  out  1  to RAM write_enable.
- ram_addr  out  AW  to RAM addr.
- ram_din  out  DATA_WIDTH  to RAM data_in.
- ram_dout  in  DATA_WIDTH  from RAM data_out; valid one cycle after the address is presented.
- busy  out  1  test in progress; RAM port owned by BIST.
- done  out  1  one-cycle pulse at end of test.
- pass  out  1  result of the last completed test; held until the next start.
- fail_addr  out  AW  address of the first mismatch.
- fail_elem  out  3  March element (0-5) of the first mismatch.
- err_count  out  8  total mismatches; saturates at 255.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: ram_we/ram_addr/ram_din = host_we/host_addr/host_din (combinational mux). Start accepted -> RUN; pass, err_count, fail_addr and fail_elem cleared.
- RUN executes the elements in order:
  - M0 up(w0).
  - M1 up(r0,w1).
  - M2 up(r1,w0).
  - M3 down(r0,w1).
  - M4 down(r1,w0).
  - M5 up(r0).
- "up" means addresses 0..DEPTH-1; "down" means DEPTH-1..0.
- Each operation is one cycle. In an r,w element, the read and write hit the same address in consecutive cycles before the address advances.
- Read cycle: ram_we=0. Write cycle: ram_we=1, ram_din = background.
- A compare is scheduled for the cycle after each read. The pipelined expect/addr/elem registers are checked against ram_dout in that cycle. The compare overlaps the following write or read.
- Mismatch handling:
  - err_count increments, saturating at 255.
  - On the first mismatch only, fail_addr and fail_elem are captured.
- After the last M5 read: DRAIN (one cycle, final compare) -> DONE.
- DONE (one cycle): done=1, pass = (err_count==0) -> IDLE.
- start in RUN/DRAIN/DONE is ignored. host_* are ignored while busy.
- rst at any time: next state IDLE; all registered outputs cleared; the mux returns to host pass-through from the next cycle. A partial test leaves no result.

## Timing
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_elem=0, err_count=0, internal addr/element counters 0. ram_* follow host_*.
- Start sampled at edge E0 -> busy=1 from E0.
- Operation k (k = 1..160) is driven in the cycle following edge E0+k-1:
  - M0: 16 cycles.
  - M1-M4: 32 cycles each.
  - M5: 16 cycles.
- DRAIN is cycle 161. busy falls and done=1 in cycle 162. pass/err_count are final at that edge.
- Total: 162 cycles from the start edge to the done pulse for DEPTH=16; in general 10*DEPTH+2.
- Address counter width AW wraps naturally. Element transition happens on terminal address (DEPTH-1 for up, 0 for down) with no idle cycle between elements.
- Compare latency is exactly 1 cycle, matching the RAM's registered read. The RAM's read-old-data behaviour on the same-edge write is never exercised, because the read precedes the write by one cycle.

## Test plan
- Fault-free RAM model, start pulse -> busy for 161 cycles, done in cycle 162, pass=1, err_count=0.
- Bit0 stuck-at-1 at addr 5 -> pass=0, fail_elem=1, fail_addr=5, err_count=3 (M1, M3, M5 reads).
- Monitor the RAM port during M3 -> addresses 15,15,14,14,...,0,0 with we pattern 0,1 alternating and din=4'hF on writes.
- start re-pulsed at cycle 40 -> ignored; done still in cycle 162, single done pulse.
- rst asserted at cycle 50 -> next cycle busy=0, err_count=0, ram_* equal host_*. Subsequent start runs a full 162-cycle test.
- Idle host write addr 3 = 4'hA, then read -> RAM returns 4'hA one cycle later. A BIST run afterwards overwrites the contents with 0 (M4 final w0).
